// File: rtl/mem_byte_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_byte_sequencer_if
//
// Purpose:
//   Bundles the control-unit handshake (MOV/MOC, MAR/MDR side) and the
//   byte-wide RAM port of the byte sequencer into one interface.
//
// Signal summary:
//   MOV       control -> seq   memory operation valid (request)
//   RW        control -> seq   1 = read, 0 = write
//   typeData  control -> seq   00 byte, 01 halfword, 10 word, 11 illegal
//   addr      control -> seq   start byte address (MAR low byte)
//   wdata     control -> seq   write data (MDR), right-justified
//   rdata     seq -> control   assembled read data, zero-extended
//   MOC       seq -> control   memory operation complete
//   err       seq -> control   illegal access size, valid with MOC
//   mem_en    seq -> RAM       byte-cycle enable
//   mem_we    seq -> RAM       write strobe
//   mem_addr  seq -> RAM       byte address
//   mem_wd    seq -> RAM       write byte
//   mem_rd    RAM -> seq       read byte, valid the cycle after a read cycle
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment (control unit plus RAM)
// ---------------------------------------------------------------------------
interface mem_byte_sequencer_if;

    logic        MOV;
    logic        RW;
    logic [1:0]  typeData;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        MOC;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wd;
    logic [7:0]  mem_rd;

    modport slave (
        input  MOV,
        input  RW,
        input  typeData,
        input  addr,
        input  wdata,
        input  mem_rd,
        output rdata,
        output MOC,
        output err,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wd
    );

    modport master (
        output MOV,
        output RW,
        output typeData,
        output addr,
        output wdata,
        output mem_rd,
        input  rdata,
        input  MOC,
        input  err,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wd
    );

endinterface

// File: rtl/mem_byte_sequencer.sv
// ---------------------------------------------------------------------------
// mem_byte_sequencer
//
// Purpose:
//   Converts one byte / halfword / word request from the control unit into
//   a run of byte-serial cycles on a 256x8 RAM. Bytes are transferred
//   big-endian: the first RAM cycle (at the start address) carries the most
//   significant byte of the access. Addresses wrap modulo 256.
//
// Ports:
//   CLK  input   clock, all state changes on the rising edge
//   CLR  input   synchronous active-high reset / transaction abort
//   bus  slave   handshake and RAM signals (see mem_byte_sequencer_if)
//
// Timing from the edge that samples MOV=1 in IDLE:
//   write of N bytes : N XFER cycles, then DONE (MOC after N+1 cycles)
//   read of N bytes  : N XFER cycles, one RTAIL cycle, then DONE (N+2)
//   illegal size     : straight to DONE with err (MOC after 1 cycle)
// ---------------------------------------------------------------------------
module mem_byte_sequencer (
    input  logic                        CLK,
    input  logic                        CLR,
    mem_byte_sequencer_if.slave         bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RTAIL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q,   state_d;
    logic        isRead_q,  isRead_d;
    logic        isErr_q,   isErr_d;
    logic [7:0]  addr_q,    addr_d;
    logic [31:0] wbuf_q,    wbuf_d;
    logic [23:0] rbuf_q,    rbuf_d;
    logic [2:0]  cnt_q,     cnt_d;
    logic        rdPend_q,  rdPend_d;
    logic [31:0] rdata_q,   rdata_d;

    // State register. CLR wins over everything, so an in-flight transfer is
    // dropped on the spot and the last read result is discarded as well.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= IDLE;
            isRead_q <= 1'b0;
            isErr_q  <= 1'b0;
            addr_q   <= 8'd0;
            wbuf_q   <= 32'd0;
            rbuf_q   <= 24'd0;
            cnt_q    <= 3'd0;
            rdPend_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            isRead_q <= isRead_d;
            isErr_q  <= isErr_d;
            addr_q   <= addr_d;
            wbuf_q   <= wbuf_d;
            rbuf_q   <= rbuf_d;
            cnt_q    <= cnt_d;
            rdPend_q <= rdPend_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state logic.
    // The request is copied into local registers on the accepting edge so
    // the control unit is free to change MAR/MDR afterwards. Write data is
    // left-aligned in wbuf so the byte to send is always wbuf[31:24] and a
    // left shift by 8 moves to the next byte. Read bytes arrive one cycle
    // after their RAM cycle; rdPend marks that the previous cycle issued a
    // read, and the bytes are shifted in from the right so the first byte
    // read ends up most significant. rdata is only written on the
    // RTAIL->DONE edge so the control unit never sees a partial value.
    always_comb begin
        state_d  = state_q;
        isRead_d = isRead_q;
        isErr_d  = isErr_q;
        addr_d   = addr_q;
        wbuf_d   = wbuf_q;
        rbuf_d   = rbuf_q;
        cnt_d    = cnt_q;
        rdPend_d = 1'b0;
        rdata_d  = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.MOV) begin
                    isRead_d = bus.RW;
                    addr_d   = bus.addr;
                    rbuf_d   = 24'd0;
                    isErr_d  = 1'b0;
                    case (bus.typeData)
                        2'b00: begin
                            cnt_d   = 3'd1;
                            wbuf_d  = bus.wdata << 24;
                            state_d = XFER;
                        end
                        2'b01: begin
                            cnt_d   = 3'd2;
                            wbuf_d  = bus.wdata << 16;
                            state_d = XFER;
                        end
                        2'b10: begin
                            cnt_d   = 3'd4;
                            wbuf_d  = bus.wdata;
                            state_d = XFER;
                        end
                        default: begin
                            cnt_d   = 3'd0;
                            wbuf_d  = 32'd0;
                            isErr_d = 1'b1;
                            state_d = DONE;
                        end
                    endcase
                end
            end

            XFER: begin
                addr_d   = addr_q + 8'd1;
                wbuf_d   = wbuf_q << 8;
                cnt_d    = cnt_q - 3'd1;
                rdPend_d = isRead_q;
                if (rdPend_q) begin
                    rbuf_d = {rbuf_q[15:0], bus.mem_rd};
                end
                if (cnt_q == 3'd1) begin
                    state_d = isRead_q ? RTAIL : DONE;
                end
            end

            RTAIL: begin
                rdata_d = {rbuf_q, bus.mem_rd};
                state_d = DONE;
            end

            DONE: begin
                if (!bus.MOV) begin
                    isErr_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. RAM-side address and data are forced to zero outside
    // XFER so the bus is quiet when no byte cycle is in progress, and the
    // write byte is only presented on write cycles.
    always_comb begin
        bus.MOC      = (state_q == DONE);
        bus.err      = (state_q == DONE) && isErr_q;
        bus.mem_en   = (state_q == XFER);
        bus.mem_we   = (state_q == XFER) && !isRead_q;
        bus.mem_addr = 8'd0;
        bus.mem_wd   = 8'd0;
        bus.rdata    = rdata_q;
        if (state_q == XFER) begin
            bus.mem_addr = addr_q;
            if (!isRead_q) begin
                bus.mem_wd = wbuf_q[31:24];
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_byte_sequencer
//
// Drives directed and random requests into mem_byte_sequencer, with a
// behavioural 256x8 RAM attached. Expected bus activity, latency and read
// data come from a byte-array model of memory plus the access rules.
// ---------------------------------------------------------------------------
module tb_mem_byte_sequencer;

    logic clk;
    logic clr;

    mem_byte_sequencer_if bus();

    mem_byte_sequencer dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0]  ram [256];
    logic [7:0]  refMem [256];
    logic        loadEn;
    logic [7:0]  loadAddr;
    logic [7:0]  loadData;
    logic [31:0] rdataModel;
    int          vectors;
    int          miscompares;

    // Behavioural RAM: synchronous write, read byte registered so it shows
    // up the cycle after the read cycle. loadEn lets the bench preload it.
    always @(posedge clk) begin
        if (loadEn) begin
            ram[loadAddr] <= loadData;
        end else if (bus.mem_en && bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wd;
        end
        if (bus.mem_en && !bus.mem_we) begin
            bus.mem_rd <= ram[bus.mem_addr];
        end
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Writes one byte into both the RAM and the reference memory
    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        loadEn   = 1'b1;
        loadAddr = a;
        loadData = d;
        refMem[a] = d;
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    // One full transaction: request, per-cycle checks, DONE hold, release
    task automatic applyStimulus(input logic rw, input logic [1:0] typ,
                                 input logic [7:0] a, input logic [31:0] wd,
                                 input bit dropEarly, input int holdCycles);
        int          n;
        int          lat;
        bit          illegal;
        bit          active;
        logic [31:0] expRead;
        logic [31:0] expFinal;
        logic [31:0] shifted;
        logic [7:0]  byteAddr;

        illegal = (typ == 2'b11);
        n       = (typ == 2'b00) ? 1 : ((typ == 2'b01) ? 2 : 4);
        lat     = illegal ? 1 : (rw ? n + 2 : n + 1);

        expRead = 32'd0;
        if (!illegal && rw) begin
            for (int k = 0; k < n; k++) begin
                byteAddr = a + 8'(k);
                expRead  = (expRead << 8) | 32'(refMem[byteAddr]);
            end
        end
        expFinal = (!illegal && rw) ? expRead : rdataModel;

        bus.MOV      = 1'b1;
        bus.RW       = rw;
        bus.typeData = typ;
        bus.addr     = a;
        bus.wdata    = wd;
        @(posedge clk);
        #1;
        bus.RW       = 1'($urandom);
        bus.typeData = 2'($urandom);
        bus.addr     = 8'($urandom);
        bus.wdata    = $urandom;
        bus.MOV      = !dropEarly;

        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            active = !illegal && (c <= n);
            checkOutput("mem_en", 32'(bus.mem_en), 32'(active));
            checkOutput("MOC", 32'(bus.MOC), 32'(c == lat));
            checkOutput("err", 32'(bus.err), 32'(illegal && (c == lat)));
            checkOutput("rdata", bus.rdata, (c == lat) ? expFinal : rdataModel);
            if (active) begin
                byteAddr = a + 8'(c - 1);
                checkOutput("mem_we", 32'(bus.mem_we), 32'(!rw));
                checkOutput("mem_addr", 32'(bus.mem_addr), 32'(byteAddr));
                if (!rw) begin
                    shifted = wd >> (8 * (n - c));
                    checkOutput("mem_wd", 32'(bus.mem_wd), 32'(shifted[7:0]));
                    refMem[byteAddr] = shifted[7:0];
                end
            end
        end
        rdataModel = expFinal;

        if (!dropEarly) begin
            for (int h = 0; h < holdCycles; h++) begin
                @(negedge clk);
                checkOutput("holdMOC", 32'(bus.MOC), 32'd1);
                checkOutput("holdMemEn", 32'(bus.mem_en), 32'd0);
                checkOutput("holdErr", 32'(bus.err), 32'(illegal));
            end
            bus.MOV = 1'b0;
        end

        @(negedge clk);
        checkOutput("releaseMOC", 32'(bus.MOC), 32'd0);
        checkOutput("releaseErr", 32'(bus.err), 32'd0);
        checkOutput("releaseMemEn", 32'(bus.mem_en), 32'd0);
        checkOutput("releaseRdata", bus.rdata, rdataModel);
    endtask

    // Word write aborted by CLR during its second byte
    task automatic abortWrite(input logic [7:0] a, input logic [31:0] wd);
        logic [31:0] shifted;
        logic [7:0]  byteAddr;

        bus.MOV      = 1'b1;
        bus.RW       = 1'b0;
        bus.typeData = 2'b10;
        bus.addr     = a;
        bus.wdata    = wd;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            byteAddr = a + 8'(c - 1);
            shifted  = wd >> (8 * (4 - c));
            checkOutput("abortMemEn", 32'(bus.mem_en), 32'd1);
            checkOutput("abortMemAddr", 32'(bus.mem_addr), 32'(byteAddr));
            checkOutput("abortMemWd", 32'(bus.mem_wd), 32'(shifted[7:0]));
            checkOutput("abortMOC", 32'(bus.MOC), 32'd0);
            refMem[byteAddr] = shifted[7:0];
        end
        clr = 1'b1;
        @(negedge clk);
        rdataModel = 32'd0;
        checkOutput("abortedMemEn", 32'(bus.mem_en), 32'd0);
        checkOutput("abortedMOC", 32'(bus.MOC), 32'd0);
        checkOutput("abortedRdata", bus.rdata, rdataModel);
        clr     = 1'b0;
        bus.MOV = 1'b0;
        @(negedge clk);
        checkOutput("postAbortMemEn", 32'(bus.mem_en), 32'd0);
        checkOutput("postAbortMOC", 32'(bus.MOC), 32'd0);
    endtask

    // Main sequence: reset, directed cases, random traffic
    initial begin
        vectors      = 0;
        miscompares  = 0;
        rdataModel   = 32'd0;
        loadEn       = 1'b0;
        loadAddr     = 8'd0;
        loadData     = 8'd0;
        clr          = 1'b1;
        bus.MOV      = 1'b1;
        bus.RW       = 1'b0;
        bus.typeData = 2'b10;
        bus.addr     = 8'd0;
        bus.wdata    = 32'd0;
        bus.mem_rd   = 8'd0;

        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            preload(8'(i), 8'($urandom));
        end

        checkOutput("rstMOC", 32'(bus.MOC), 32'd0);
        checkOutput("rstErr", 32'(bus.err), 32'd0);
        checkOutput("rstMemEn", 32'(bus.mem_en), 32'd0);
        checkOutput("rstMemWe", 32'(bus.mem_we), 32'd0);
        checkOutput("rstMemAddr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rstMemWd", 32'(bus.mem_wd), 32'd0);
        checkOutput("rstRdata", bus.rdata, 32'd0);

        clr     = 1'b0;
        bus.MOV = 1'b0;
        @(negedge clk);
        checkOutput("idleMOC", 32'(bus.MOC), 32'd0);
        checkOutput("idleMemEn", 32'(bus.mem_en), 32'd0);

        applyStimulus(1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 1'b0, 1);
        applyStimulus(1'b1, 2'b10, 8'h10, 32'h0, 1'b1, 0);
        preload(8'hFF, 8'h12);
        preload(8'h00, 8'h34);
        applyStimulus(1'b1, 2'b01, 8'hFF, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 2'b00, 8'h20, 32'h000000A5, 1'b0, 0);
        applyStimulus(1'b1, 2'b00, 8'h20, 32'h0, 1'b0, 2);
        applyStimulus(1'b0, 2'b11, 8'h30, 32'h00001234, 1'b0, 1);
        applyStimulus(1'b1, 2'b11, 8'h31, 32'h0, 1'b1, 0);
        abortWrite(8'h40, 32'h01234567);
        applyStimulus(1'b1, 2'b10, 8'h40, 32'h0, 1'b0, 0);

        for (int t = 0; t < 80; t++) begin
            applyStimulus(1'($urandom), 2'($urandom), 8'($urandom), $urandom,
                          1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
